// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS-subset controller.
//   - opcode / func field constants
//   - controller state enum (TRAP exists only with MC_ILLEGAL_TRAP_EN)
//   - ALU control codes, alu_src_b and pc_src encodings
//   - ctrl_t bundle of the state-decoded (Moore) datapath controls
// Optional build macro: MC_ILLEGAL_TRAP_EN
package mc_pkg;

   localparam int STATE_W = 4;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b100;
   localparam logic [2:0] ALU_OR   = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PC_ALU = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   typedef enum logic [STATE_W-1:0] {
      S_RST, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM,
      S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_BRANCH,
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP,
`endif
      S_JUMP
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic [1:0] pc_src;
      logic       reg_wr;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_op;
      logic [2:0] alu_ctr;
   } ctrl_t;

   // Controls that depend only on the state being entered. alu_dec/ext_dec
   // come from the IR fields and only matter in the execute states.
   function automatic ctrl_t moore_ctrl(state_t s, logic [2:0] alu_dec, logic ext_dec);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req = 1'b1; c.alu_src_b = SRCB_FOUR; c.alu_ctr = ALU_ADD; c.pc_src = PC_ALU;
         end
         S_DECODE: begin
            c.alu_src_b = SRCB_IMM_SH; c.ext_op = 1'b1; c.alu_ctr = ALU_ADD;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.ext_op = 1'b1; c.alu_ctr = ALU_ADD;
         end
         S_MEM_RD: begin
            c.mem_req = 1'b1; c.i_or_d = 1'b1;
         end
         S_MEM_WR: begin
            c.mem_req = 1'b1; c.mem_we = 1'b1; c.i_or_d = 1'b1;
         end
         S_WB_MEM: begin
            c.reg_wr = 1'b1; c.mem_to_reg = 1'b1;
         end
         S_EXEC_R: begin
            c.alu_src_a = 1'b1; c.alu_src_b = SRCB_RT; c.alu_ctr = alu_dec;
         end
         S_WB_R: begin
            c.reg_wr = 1'b1; c.reg_dst = 1'b1;
         end
         S_EXEC_I: begin
            c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.ext_op = ext_dec; c.alu_ctr = alu_dec;
         end
         S_WB_I: c.reg_wr = 1'b1;
         S_BRANCH: begin
            c.alu_src_a = 1'b1; c.alu_src_b = SRCB_RT; c.alu_ctr = ALU_SUB; c.pc_src = PC_BR;
         end
         S_JUMP: c.pc_src = PC_JMP;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: controller <-> datapath/memory signal bundle.
//   master (controller): in op, func, zero, mem_ready; out all enables/selects,
//                        alu_ctr, instr_done, mem_err (+ illegal with MC_ILLEGAL_TRAP_EN)
//   slave  (datapath)  : the mirror image
// Optional build macro: MC_ILLEGAL_TRAP_EN
interface mc_ctrl_fsm_if;
   logic [5:0] op;
   logic [5:0] func;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_we;
   logic       i_or_d;
   logic       ir_wr;
   logic       pc_wr;
   logic [1:0] pc_src;
   logic       reg_wr;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       ext_op;
   logic [2:0] alu_ctr;
   logic       instr_done;
   logic       mem_err;
`ifdef MC_ILLEGAL_TRAP_EN
   logic       illegal;
`endif

   modport master (
      input  op, func, zero, mem_ready,
      output mem_req, mem_we, i_or_d, ir_wr, pc_wr, pc_src, reg_wr, reg_dst,
             mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_ctr, instr_done, mem_err
`ifdef MC_ILLEGAL_TRAP_EN
      , illegal
`endif
   );

   modport slave (
      output op, func, zero, mem_ready,
      input  mem_req, mem_we, i_or_d, ir_wr, pc_wr, pc_src, reg_wr, reg_dst,
             mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_ctr, instr_done, mem_err
`ifdef MC_ILLEGAL_TRAP_EN
      , illegal
`endif
   );
endinterface

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational ALU control from the IR fields.
//   op, func -> alu_ctr   (R-type by func, ori -> OR, everything else -> ADD)
//   func_ok (MC_ILLEGAL_TRAP_EN only): 0 for an unrecognised R-type func
// Unknown funcs fall back to ADD so the default build executes them as addu.
module mc_alu_dec
   import mc_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] func,
   output logic [2:0] alu_ctr
`ifdef MC_ILLEGAL_TRAP_EN
   , output logic     func_ok
`endif
);

   logic fn_known;

   always_comb begin
      alu_ctr  = ALU_ADD;
      fn_known = 1'b1;
      if (op == OP_R) begin
         case (func)
            FN_ADDU: alu_ctr = ALU_ADD;
            FN_SUBU: alu_ctr = ALU_SUB;
            FN_AND:  alu_ctr = ALU_AND;
            FN_OR:   alu_ctr = ALU_OR;
            FN_SLT:  alu_ctr = ALU_SLT;
            default: fn_known = 1'b0;
         endcase
      end else if (op == OP_ORI) begin
         alu_ctr = ALU_OR;
      end
   end

`ifdef MC_ILLEGAL_TRAP_EN
   assign func_ok = fn_known;
`else
   // Only the trap build cares whether func was recognised.
   logic unused_fn;
   assign unused_fn = fn_known;
`endif

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS-subset main controller.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (master): IR fields op/func, ALU zero, memory handshake in;
//                 datapath enables/selects, alu_ctr, instr_done, mem_err out
// Moore controls are registered from the next state, so they change on the
// state edge and clear asynchronously with reset. ir_wr, pc_wr and
// instr_done are decoded from the state register and qualified by
// mem_ready / zero in the same cycle.
// Memory waits (FETCH, MEM_RD, MEM_WR) abort after MEM_TIMEOUT cycles without
// mem_ready (0 = never); mem_err pulses in the following FETCH cycle.
// Optional build macro: MC_ILLEGAL_TRAP_EN (unknown op/func -> sticky TRAP,
// illegal output).
module mc_ctrl_fsm
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input logic           clk,
   input logic           rst_n,
   mc_ctrl_fsm_if.master bus
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_t           state, nxt;
   ctrl_t            ctl;
   logic [CNT_W-1:0] wcnt;
   logic             mem_st, expire, mem_err_q;
   logic [2:0]       alu_dec;
   logic             ext_dec;
`ifdef MC_ILLEGAL_TRAP_EN
   logic             func_ok, illegal_q;
`endif

   mc_alu_dec u_dec (
      .op      (bus.op),
      .func    (bus.func),
      .alu_ctr (alu_dec)
`ifdef MC_ILLEGAL_TRAP_EN
      , .func_ok (func_ok)
`endif
   );

   assign ext_dec = (bus.op != OP_ORI);
   assign mem_st  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   // A ready on the expiry edge completes the access, hence the !mem_ready term.
   assign expire  = (MEM_TIMEOUT != 0) && mem_st && !bus.mem_ready &&
                    (wcnt == CNT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      nxt = state;
      case (state)
         S_RST:    nxt = S_FETCH;
         S_FETCH:  if (bus.mem_ready) nxt = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW:     nxt = S_MEM_ADDR;
               OP_R:             nxt = S_EXEC_R;
               OP_ORI, OP_ADDIU: nxt = S_EXEC_I;
               OP_BEQ:           nxt = S_BRANCH;
               OP_J:             nxt = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
               default:          nxt = S_TRAP;
`else
               default:          nxt = S_FETCH;
`endif
            endcase
         end
         S_MEM_ADDR: nxt = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (bus.mem_ready) nxt = S_WB_MEM;
         S_MEM_WR:   if (bus.mem_ready) nxt = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
         S_EXEC_R:   nxt = func_ok ? S_WB_R : S_TRAP;
         S_TRAP:     nxt = S_TRAP;
`else
         S_EXEC_R:   nxt = S_WB_R;
`endif
         S_EXEC_I:   nxt = S_WB_I;
         default:    nxt = S_FETCH;
      endcase
      if (expire) nxt = S_FETCH;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_RST;
         ctl       <= '0;
         wcnt      <= '0;
         mem_err_q <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state     <= nxt;
         ctl       <= moore_ctrl(nxt, alu_dec, ext_dec);
         mem_err_q <= expire;
         // Every exit from a wait (ready, expiry, or a non-memory state)
         // clears the counter, so entry into a memory state always sees 0.
         wcnt      <= (MEM_TIMEOUT != 0 && mem_st && !bus.mem_ready && !expire) ?
                      wcnt + 1'b1 : '0;
`ifdef MC_ILLEGAL_TRAP_EN
         illegal_q <= (nxt == S_TRAP);
`endif
      end
   end

   assign bus.mem_req    = ctl.mem_req;
   assign bus.mem_we     = ctl.mem_we;
   assign bus.i_or_d     = ctl.i_or_d;
   assign bus.pc_src     = ctl.pc_src;
   assign bus.reg_wr     = ctl.reg_wr;
   assign bus.reg_dst    = ctl.reg_dst;
   assign bus.mem_to_reg = ctl.mem_to_reg;
   assign bus.alu_src_a  = ctl.alu_src_a;
   assign bus.alu_src_b  = ctl.alu_src_b;
   assign bus.ext_op     = ctl.ext_op;
   assign bus.alu_ctr    = ctl.alu_ctr;
   assign bus.mem_err    = mem_err_q;
`ifdef MC_ILLEGAL_TRAP_EN
   assign bus.illegal    = illegal_q;
`endif

   assign bus.ir_wr      = (state == S_FETCH) && bus.mem_ready;
   assign bus.pc_wr      = ((state == S_FETCH) && bus.mem_ready) || (state == S_JUMP) ||
                           ((state == S_BRANCH) && bus.zero);
   assign bus.instr_done = (state == S_WB_MEM) || (state == S_WB_R) || (state == S_WB_I) ||
                           (state == S_BRANCH) || (state == S_JUMP) ||
                           ((state == S_MEM_WR) && bus.mem_ready);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed bench for mc_ctrl_fsm (MEM_TIMEOUT = 4).
// Each directed instruction is expanded into its expected per-cycle phase
// trace; a negedge process compares every output against it. Latencies,
// retire counts, mem_err counts and reset values are also pinned as literals.
module tb_mc_ctrl_fsm;

   localparam int TO = 4;

   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                          ORI = 6'b001101, ADDIU = 6'b001001, BEQ = 6'b000100,
                          J = 6'b000010, BAD = 6'b111111;

   typedef struct packed {
      logic       mem_req, mem_we, i_or_d, ir_wr, pc_wr;
      logic [1:0] pc_src;
      logic       reg_wr, reg_dst, mem_to_reg, alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_op;
      logic [2:0] alu_ctr;
      logic       instr_done, mem_err, illegal;
   } obs_t;

   logic clk = 1'b0, rst_n = 1'b1;
   always #5 clk = ~clk;

   mc_ctrl_fsm_if bus ();
   mc_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic ill;
`ifdef MC_ILLEGAL_TRAP_EN
   assign ill = bus.illegal;
`else
   assign ill = 1'b0;
`endif

   obs_t act;
   assign act = {bus.mem_req, bus.mem_we, bus.i_or_d, bus.ir_wr, bus.pc_wr, bus.pc_src,
                 bus.reg_wr, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                 bus.ext_op, bus.alu_ctr, bus.instr_done, bus.mem_err, ill};

   int    checks = 0, failures = 0;
   int    cyc_no = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0;
   obs_t  exp_cur;
   string tag;
   logic  chk_en = 1'b0;
   logic  ld = 1'b0, nz = 1'b0;
   logic [5:0] nop = '0, nfunc = '0;

   // ---- expected outputs of each phase --------------------------------
   function automatic obs_t o_fetch(logic rdy, logic err);
      obs_t o = '0;
      o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_wr = rdy; o.pc_wr = rdy; o.mem_err = err;
      return o;
   endfunction
   function automatic obs_t o_decode();
      obs_t o = '0; o.alu_src_b = 2'b11; o.ext_op = 1; return o;
   endfunction
   function automatic obs_t o_memaddr();
      obs_t o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10; o.ext_op = 1; return o;
   endfunction
   function automatic obs_t o_memrd();
      obs_t o = '0; o.mem_req = 1; o.i_or_d = 1; return o;
   endfunction
   function automatic obs_t o_memwr(logic rdy);
      obs_t o = '0; o.mem_req = 1; o.mem_we = 1; o.i_or_d = 1; o.instr_done = rdy; return o;
   endfunction
   function automatic obs_t o_wbmem();
      obs_t o = '0; o.reg_wr = 1; o.mem_to_reg = 1; o.instr_done = 1; return o;
   endfunction
   function automatic obs_t o_execr(logic [5:0] f);
      obs_t o = '0;
      o.alu_src_a = 1;
      case (f)
         6'b100011: o.alu_ctr = 3'b100;
         6'b100100: o.alu_ctr = 3'b011;
         6'b100101: o.alu_ctr = 3'b010;
         6'b101010: o.alu_ctr = 3'b111;
         default:   o.alu_ctr = 3'b000;
      endcase
      return o;
   endfunction
   function automatic obs_t o_wbr();
      obs_t o = '0; o.reg_wr = 1; o.reg_dst = 1; o.instr_done = 1; return o;
   endfunction
   function automatic obs_t o_execi(logic [5:0] op);
      obs_t o = '0;
      o.alu_src_a = 1; o.alu_src_b = 2'b10;
      o.ext_op  = (op == ADDIU);
      o.alu_ctr = (op == ORI) ? 3'b010 : 3'b000;
      return o;
   endfunction
   function automatic obs_t o_wbi();
      obs_t o = '0; o.reg_wr = 1; o.instr_done = 1; return o;
   endfunction
   function automatic obs_t o_branch(logic z);
      obs_t o = '0;
      o.alu_src_a = 1; o.alu_ctr = 3'b100; o.pc_src = 2'b01; o.pc_wr = z; o.instr_done = 1;
      return o;
   endfunction
   function automatic obs_t o_jump();
      obs_t o = '0; o.pc_src = 2'b10; o.pc_wr = 1; o.instr_done = 1; return o;
   endfunction
   function automatic obs_t o_trap();
      obs_t o = '0; o.illegal = 1; return o;
   endfunction

   // ---- per-cycle compare ---------------------------------------------
   always @(negedge clk) begin
      cyc_no++;
      if (bus.instr_done === 1'b1) begin done_cnt++; done_cyc = cyc_no; end
      if (bus.mem_err === 1'b1) err_cnt++;
      if (chk_en) begin
         checks++;
         if (act !== exp_cur) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %b want %b", tag, cyc_no, act, exp_cur);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   // One clock cycle: inputs change just after the edge, check at negedge.
   task automatic cyc(input string t, input logic rdy, input obs_t e);
      @(posedge clk); #1;
      if (ld) begin bus.op = nop; bus.func = nfunc; bus.zero = nz; ld = 1'b0; end
      bus.mem_ready = rdy; exp_cur = e; tag = t; chk_en = 1'b1;
   endtask

   // fw: fetch wait cycles (TO = fetch timeout), mw: memory wait cycles
   // (>= TO = timeout), err0: first fetch cycle shows the previous timeout,
   // lat: expected retire latency in cycles (0 = must not retire).
   task automatic run(input string nm, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input int fw, input int mw, input logic err0,
                      input int lat);
      int st, d0;
      st = cyc_no + 1; d0 = done_cnt;
      nop = o; nfunc = f; nz = z; ld = 1'b1;
      for (int k = 0; k <= fw; k++)
         cyc({nm, " fetch"}, k == fw, o_fetch(k == fw, (k == 0 && err0) || k == TO));
      cyc({nm, " decode"}, 1'b1, o_decode());
      case (o)
         LW, SW: begin
            cyc({nm, " memaddr"}, 1'b1, o_memaddr());
            for (int i = 0; i < mw && i < TO; i++)
               cyc({nm, " memwait"}, 1'b0, (o == LW) ? o_memrd() : o_memwr(1'b0));
            if (mw < TO) begin
               if (o == LW) begin
                  cyc({nm, " memrd"}, 1'b1, o_memrd());
                  cyc({nm, " wbmem"}, 1'b1, o_wbmem());
               end else begin
                  cyc({nm, " memwr"}, 1'b1, o_memwr(1'b1));
               end
            end
         end
         R: begin
            cyc({nm, " execr"}, 1'b1, o_execr(f));
            cyc({nm, " wbr"}, 1'b1, o_wbr());
         end
         ORI, ADDIU: begin
            cyc({nm, " execi"}, 1'b1, o_execi(o));
            cyc({nm, " wbi"}, 1'b1, o_wbi());
         end
         BEQ: cyc({nm, " branch"}, 1'b1, o_branch(z));
         J:   cyc({nm, " jump"}, 1'b1, o_jump());
         default: ;
      endcase
      @(negedge clk); #1;
      if (lat > 0) begin
         chk({nm, " retired"}, done_cnt, d0 + 1);
         chk({nm, " latency"}, done_cyc - st + 1, lat);
      end else begin
         chk({nm, " no retire"}, done_cnt, d0);
      end
   endtask

   task automatic do_reset(input string nm);
      #1; chk_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk({nm, " async all0"}, act, 0);
      chk({nm, " mem_we"}, bus.mem_we, 0);
      repeat (2) @(negedge clk);
      #1;
      chk({nm, " hold all0"}, act, 0);
      rst_n = 1'b1;
   endtask

   logic [5:0] fns [4];

   initial begin
      bus.op = '0; bus.func = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      fns[0] = 6'b100011; fns[1] = 6'b100100; fns[2] = 6'b100101; fns[3] = 6'b101010;
      #1 rst_n = 1'b0;
      #2;
      chk("reset all0", act, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      run("addu",  R,     6'b100001, 1'b0, 0, 0, 1'b0, 4);
      run("lw_w2", LW,    6'b000000, 1'b0, 0, 2, 1'b0, 7);
      run("sw_w1", SW,    6'b000000, 1'b0, 0, 1, 1'b0, 5);
      run("ori",   ORI,   6'b000000, 1'b0, 0, 0, 1'b0, 4);
      run("addiu", ADDIU, 6'b000000, 1'b0, 0, 0, 1'b0, 4);
      foreach (fns[i]) run("rfunc", R, fns[i], 1'b0, 0, 0, 1'b0, 4);
`ifndef MC_ILLEGAL_TRAP_EN
      run("badfunc", R, 6'b111111, 1'b0, 0, 0, 1'b0, 4);
`endif
      run("beq_z1", BEQ, 6'b000000, 1'b1, 0, 0, 1'b0, 3);
      run("beq_z0", BEQ, 6'b000000, 1'b0, 0, 0, 1'b0, 3);
      run("j",      J,   6'b000000, 1'b0, 0, 0, 1'b0, 3);
      chk("no err yet", err_cnt, 0);

      run("fetch_to",  R,   6'b100001, 1'b0, TO, 0, 1'b0, 8);
      chk("fetch_to err", err_cnt, 1);
      run("fetch_win", ORI, 6'b000000, 1'b0, TO - 1, 0, 1'b0, 7);
      chk("fetch_win err", err_cnt, 1);
      run("lw_to",   LW, 6'b000000, 1'b0, 0, TO, 1'b0, 0);
      run("j_after", J,  6'b000000, 1'b0, 0, 0, 1'b1, 3);
      chk("lw_to err", err_cnt, 2);

      run("badop", BAD, 6'b000000, 1'b0, 0, 0, 1'b0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
      for (int i = 0; i < 4; i++) cyc("trap", i[0], o_trap());
      @(negedge clk);
      do_reset("trap reset");
`endif

      // Abort a store while it waits for memory.
      nop = SW; nfunc = '0; nz = 1'b0; ld = 1'b1;
      cyc("sw fetch", 1'b1, o_fetch(1'b1, 1'b0));
      cyc("sw decode", 1'b1, o_decode());
      cyc("sw memaddr", 1'b1, o_memaddr());
      cyc("sw memwr", 1'b0, o_memwr(1'b0));
      @(negedge clk);
      do_reset("memwr reset");
      run("addu_post", R, 6'b100001, 1'b0, 0, 0, 1'b0, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
